// File: rtl/ternary_matvec_seq.sv
// ternary_matvec_seq: sequential ternary matrix-vector multiply, y[i] = sum_j m[i][j]*x[j], one column per cycle.
// Latency: operands accepted at edge N, out_valid_o is registered high after edge N+P_D; one result per P_D+2 cycles.
// Backpressure: in_ready_o only in IDLE; result is held stable in DONE until out_valid_o && out_ready_i.
// Optional build macro: TERNARY_MATVEC_SATURATE_EN (clamp outputs instead of modular wrap).

package config_pkg;
   localparam int D    = 4;
   localparam int FP_W = 8;

   // Raw two's complement fixed-point sample; the exponent is implied and shared by x and y
   typedef logic signed [FP_W-1:0] fixed_point_t;
   // Ternary weight: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0, 2'b10 is illegal and acts as 0
   typedef logic [1:0]             ternary_t;
   typedef ternary_t     [D-1:0]   ternary_row_t;
   // m[i][j]: row i, column j
   typedef ternary_row_t [D-1:0]   ternary_matrix_t;
   typedef fixed_point_t [D-1:0]   vector_t;
endpackage

module ternary_matvec_seq
   import config_pkg::*;
#(
   // Must equal config_pkg::D, since the port types are sized by the package
   parameter int P_D     = config_pkg::D,
   parameter int P_ACC_W = $bits(fixed_point_t) + $clog2(P_D) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  ternary_matrix_t in_matrix_i,
   input  vector_t         in_vector_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output vector_t         out_vector_o,
   output logic            busy_o
);

   localparam int W     = $bits(fixed_point_t);
   localparam int COL_W = $clog2(P_D);

   typedef logic signed [P_ACC_W-1:0] acc_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e            state_q;
   ternary_matrix_t   mat_q;
   vector_t           vec_q;
   acc_t              acc_q [P_D];
   acc_t              acc_d [P_D];
   acc_t              x_sext;
   logic [COL_W-1:0]  col_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;
   vector_t           out_vec;

`ifdef TERNARY_MATVEC_SATURATE_EN
   // Largest / smallest fixed_point_t values expressed at accumulator width
   localparam acc_t FP_MAX = {{(P_ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam acc_t FP_MIN = ~FP_MAX;
`endif

   // Per-lane add/subtract/hold of the current column's x element
   always_comb begin
      x_sext = acc_t'($signed(vec_q[col_q]));
      for (int i = 0; i < P_D; i++) begin
         acc_d[i] = acc_q[i];
         case (mat_q[i][col_q])
            2'b01:   acc_d[i] = acc_q[i] + x_sext;
            2'b11:   acc_d[i] = acc_q[i] - x_sext;
            default: acc_d[i] = acc_q[i];
         endcase
      end
   end

   // Narrow each accumulator to fixed_point_t for the output
   always_comb begin
      out_vec = '0;
      for (int i = 0; i < P_D; i++) begin
`ifdef TERNARY_MATVEC_SATURATE_EN
         if (acc_q[i] > FP_MAX) begin
            out_vec[i] = fixed_point_t'(FP_MAX);
         end else if (acc_q[i] < FP_MIN) begin
            out_vec[i] = fixed_point_t'(FP_MIN);
         end else begin
            out_vec[i] = acc_q[i][W-1:0];
         end
`else
         out_vec[i] = acc_q[i][W-1:0];
`endif
      end
   end

   // Control FSM with registered handshake outputs, operand capture and accumulation
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         col_q       <= '0;
         mat_q       <= '0;
         vec_q       <= '0;
         for (int i = 0; i < P_D; i++) acc_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i && in_ready_q) begin
                  mat_q      <= in_matrix_i;
                  vec_q      <= in_vector_i;
                  col_q      <= '0;
                  for (int i = 0; i < P_D; i++) acc_q[i] <= '0;
                  state_q    <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               for (int i = 0; i < P_D; i++) acc_q[i] <= acc_d[i];
               if (col_q == COL_W'(P_D - 1)) begin
                  col_q       <= '0;
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o   = in_ready_q;
   assign out_valid_o  = out_valid_q;
   assign busy_o       = busy_q;
   assign out_vector_o = out_vec;

endmodule
